// File: rtl/interval_timer_pkg.sv
// Shared codes, widths and default times for the light controller timing path.
package interval_timer_pkg;

   // Duration codes driven by the controller FSM on `interval`
   localparam logic [1:0] IV_BASE   = 2'b00;
   localparam logic [1:0] IV_EXT    = 2'b01;
   localparam logic [1:0] IV_YEL    = 2'b10;
   localparam logic [1:0] IV_BASEx2 = 2'b11;

   // Parameter-write targets on `Time_Param_Sel` (11 writes nothing)
   localparam logic [1:0] SEL_BASE = 2'b00;
   localparam logic [1:0] SEL_EXT  = 2'b01;
   localparam logic [1:0] SEL_YEL  = 2'b10;

   // Stored time width and countdown width (2 x 15 s fits in 5 bits)
   localparam int TW = 4;
   localparam int DW = 5;

   // Default times in seconds
   localparam int DEF_BASE_S = 6;
   localparam int DEF_EXT_S  = 3;
   localparam int DEF_YEL_S  = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } tmr_state_e;

   // Map an interval code onto a duration in seconds
   function automatic logic [DW-1:0] decode_dur(
      input logic [1:0]    iv,
      input logic [TW-1:0] t_base,
      input logic [TW-1:0] t_ext,
      input logic [TW-1:0] t_yel
   );
      logic [DW-1:0] d;
      case (iv)
         IV_BASE: d = {1'b0, t_base};
         IV_EXT:  d = {1'b0, t_ext};
         IV_YEL:  d = {1'b0, t_yel};
         default: d = {t_base, 1'b0};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/interval_timer_tick_divider.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, parks at 0 otherwise.
module tick_divider #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic Reset_Sync,
   input  logic clear,
   input  logic enable,
   output logic tick
);
   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   // Tick marks the last cycle of each one-second window
   assign tick = enable && (r_cnt == C_LAST);

   // Prescaler: clear wins, wraps at TICK_DIV-1, held at 0 when not enabled
   always_ff @(posedge clk or posedge Reset_Sync) begin
      if (Reset_Sync)            r_cnt <= '0;
      else if (clear || !enable) r_cnt <= '0;
      else if (r_cnt == C_LAST)  r_cnt <= '0;
      else                       r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/interval_timer.sv
// Countdown timer answering the controller's start/expired handshake.
// Holds tBASE/tEXT/tYEL, decodes the requested duration and counts it in seconds.
module interval_timer
   import interval_timer_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000,
   parameter int DEF_BASE = DEF_BASE_S,
   parameter int DEF_EXT  = DEF_EXT_S,
   parameter int DEF_YEL  = DEF_YEL_S
) (
   input  logic          clk,
   input  logic          Reset_Sync,
   input  logic          Prog_Sync,
   input  logic [1:0]    Time_Param_Sel,
   input  logic [TW-1:0] Time_Value,
   input  logic [1:0]    interval,
   input  logic          start_timer,
   output logic          expired,
   output logic          busy,
   output logic [DW-1:0] remaining
);
   localparam logic [TW-1:0] C_DEF_BASE = TW'(DEF_BASE);
   localparam logic [TW-1:0] C_DEF_EXT  = TW'(DEF_EXT);
   localparam logic [TW-1:0] C_DEF_YEL  = TW'(DEF_YEL);

   logic [TW-1:0] r_t_base, r_t_ext, r_t_yel;
   tmr_state_e    r_state;
   logic [DW-1:0] r_remaining;
   logic          r_expired;
   logic [DW-1:0] w_dur;
   logic          w_tick;
   logic          w_busy;

   assign w_busy    = (r_state == ST_RUN);
   assign busy      = w_busy;
   assign remaining = r_remaining;
   assign expired   = r_expired;

   // Duration uses the parameter values held before the start edge
   assign w_dur = decode_dur(interval, r_t_base, r_t_ext, r_t_yel);

   // Parameter registers; a zero write restores the default so D is never 0
   always_ff @(posedge clk or posedge Reset_Sync) begin
      if (Reset_Sync) begin
         r_t_base <= C_DEF_BASE;
         r_t_ext  <= C_DEF_EXT;
         r_t_yel  <= C_DEF_YEL;
      end else if (Prog_Sync) begin
         case (Time_Param_Sel)
            SEL_BASE: r_t_base <= (Time_Value == '0) ? C_DEF_BASE : Time_Value;
            SEL_EXT:  r_t_ext  <= (Time_Value == '0) ? C_DEF_EXT  : Time_Value;
            SEL_YEL:  r_t_yel  <= (Time_Value == '0) ? C_DEF_YEL  : Time_Value;
            default:  ;
         endcase
      end
   end

   // Prescaler restarts on every start so the first second is a full one
   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_divider (
      .clk        (clk),
      .Reset_Sync (Reset_Sync),
      .clear      (start_timer),
      .enable     (w_busy),
      .tick       (w_tick)
   );

   // Countdown FSM; a start beats a coincident final tick, so no pulse then
   always_ff @(posedge clk or posedge Reset_Sync) begin
      if (Reset_Sync) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
         r_expired   <= 1'b0;
      end else begin
         r_expired <= 1'b0;
         if (start_timer) begin
            r_state     <= ST_RUN;
            r_remaining <= w_dur;
         end else if (r_state == ST_RUN && w_tick) begin
            if (r_remaining > DW'(1)) begin
               r_remaining <= r_remaining - 1'b1;
            end else begin
               r_remaining <= '0;
               r_state     <= ST_IDLE;
               r_expired   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with a 4-cycle second.
module tb_interval_timer;
   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       Reset_Sync;
   logic       Prog_Sync;
   logic [1:0] Time_Param_Sel;
   logic [3:0] Time_Value;
   logic [1:0] interval;
   logic       start_timer;
   logic       expired;
   logic       busy;
   logic [4:0] remaining;

   int errors = 0;
   int checks = 0;

   interval_timer #(
      .TICK_DIV (TD)
   ) dut (
      .clk            (clk),
      .Reset_Sync     (Reset_Sync),
      .Prog_Sync      (Prog_Sync),
      .Time_Param_Sel (Time_Param_Sel),
      .Time_Value     (Time_Value),
      .interval       (interval),
      .start_timer    (start_timer),
      .expired        (expired),
      .busy           (busy),
      .remaining      (remaining)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       do_prog;
      logic [1:0] sel;
      logic [3:0] val;
      logic [1:0] iv;
      int         exp_d;
      int         exp_lat;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one edge and settle 1 ns past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input logic [1:0] sel, input logic [3:0] val);
      Prog_Sync = 1'b1; Time_Param_Sel = sel; Time_Value = val;
      step();
      Prog_Sync = 1'b0;
   endtask

   task automatic start(input logic [1:0] iv);
      interval = iv; start_timer = 1'b1;
      step();
      start_timer = 1'b0;
   endtask

   // Edges from the start edge until expired is seen; -1 on timeout
   task automatic wait_exp(output int lat);
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
         step();
         if (expired === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_and_expire(input string name, input int exp_lat);
      int lat;
      wait_exp(lat);
      chk({name, " latency"}, lat, exp_lat);
      chk({name, " busy at expiry"}, int'(busy), 0);
      chk({name, " remaining at expiry"}, int'(remaining), 0);
      step();
      chk({name, " pulse width"}, int'(expired), 0);
   endtask

   task automatic check_params(input string name, input int b, input int e, input int y);
      start(2'b00); chk({name, " tBASE"}, int'(remaining), b);
      start(2'b01); chk({name, " tEXT"},  int'(remaining), e);
      start(2'b10); chk({name, " tYEL"},  int'(remaining), y);
   endtask

   initial begin
      int pulses;
      int bad;

      // do_prog sel val iv D latency(D*4)
      vecs[0] = '{1'b0, 2'b00, 4'd0,  2'b00, 6,  24};
      vecs[1] = '{1'b1, 2'b10, 4'd5,  2'b10, 5,  20};
      vecs[2] = '{1'b1, 2'b00, 4'd0,  2'b11, 12, 48};
      vecs[3] = '{1'b1, 2'b01, 4'd7,  2'b01, 7,  28};
      vecs[4] = '{1'b1, 2'b00, 4'd15, 2'b11, 30, 120};

      Reset_Sync = 1'b1; Prog_Sync = 1'b0; Time_Param_Sel = 2'b00;
      Time_Value = 4'd0; interval = 2'b00; start_timer = 1'b0;
      step(); step();
      chk("reset expired", int'(expired), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset remaining", int'(remaining), 0);
      Reset_Sync = 1'b0;
      step();

      for (int i = 0; i < 5; i++) begin
         if (vecs[i].do_prog) prog(vecs[i].sel, vecs[i].val);
         start(vecs[i].iv);
         chk($sformatf("vec%0d load", i), int'(remaining), vecs[i].exp_d);
         chk($sformatf("vec%0d busy", i), int'(busy), 1);
         run_and_expire($sformatf("vec%0d", i), vecs[i].exp_lat);
      end

      // Fresh reset: parameters 6/3/2
      Reset_Sync = 1'b1; #2; Reset_Sync = 1'b0;
      step();

      // Restart mid-run: D=3 started, D=2 restart six edges later
      start(2'b01);
      for (int k = 0; k < 5; k++) step();
      start(2'b10);
      chk("restart load", int'(remaining), 2);
      run_and_expire("restart", 8);
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (expired === 1'b1) pulses++;
      end
      chk("restart extra pulses", pulses, 0);

      // Start coinciding with the final tick: reload, no pulse
      start(2'b10);
      for (int k = 0; k < 7; k++) step();
      start(2'b10);
      chk("final-tick start expired", int'(expired), 0);
      chk("final-tick start remaining", int'(remaining), 2);
      chk("final-tick start busy", int'(busy), 1);
      run_and_expire("final-tick reload", 8);

      // Write and start on the same edge: load sees the old tYEL
      Prog_Sync = 1'b1; Time_Param_Sel = 2'b10; Time_Value = 4'd4;
      start(2'b10);
      Prog_Sync = 1'b0;
      chk("prog+start old value", int'(remaining), 2);
      run_and_expire("prog+start", 8);
      start(2'b10);
      chk("new tYEL used next", int'(remaining), 4);

      // Write during a run does not alter the count in progress
      start(2'b00);
      prog(2'b00, 4'd9);
      run_and_expire("mid-run write", 23);

      // Asynchronous reset with remaining=4 (params now 9/3/4)
      start(2'b01);
      prog(2'b01, 4'd8);
      start(2'b00);
      for (int k = 0; k < 8; k++) step();
      chk("pre-reset remaining", int'(remaining), 7);
      start(2'b01);
      for (int k = 0; k < 16; k++) step();
      chk("pre-reset remaining4", int'(remaining), 4);
      Reset_Sync = 1'b1;
      #1;
      chk("async reset busy", int'(busy), 0);
      chk("async reset remaining", int'(remaining), 0);
      chk("async reset expired", int'(expired), 0);
      step();
      Reset_Sync = 1'b0;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (expired === 1'b1 || busy === 1'b1) pulses++;
      end
      chk("post-reset quiet", pulses, 0);
      check_params("post-reset", 6, 3, 2);
      run_and_expire("post-reset tYEL", 8);

      // Long idle after expiry
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (expired !== 1'b0 || remaining !== 5'd0 || busy !== 1'b0) bad++;
      end
      chk("idle 100 cycles", bad, 0);

      // Selector 11 writes nothing
      prog(2'b11, 4'd9);
      check_params("sel11", 6, 3, 2);
      start(2'b11);
      chk("sel11 2xBASE", int'(remaining), 12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
